// File: rtl/fp_mult_stream_ctrl.sv
// Streaming valid/ready wrapper around a fixed-latency registered FP multiplier.
// Credit-based issue keeps every in-flight result guaranteed a slot in the result FIFO.
module fp_mult_stream_ctrl #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic [31:0]      mult_z,
  input  logic [7:0]       mult_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status,
  input  logic             sticky_clr,
  output logic [7:0]       sticky_status,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int unsigned Z_W    = 32;
  localparam int unsigned ST_W   = 8;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(DEPTH + LATENCY + 2);

  logic [LATENCY:0]  vld_pipe;
  logic [Z_W-1:0]    fifo_z  [DEPTH];
  logic [ST_W-1:0]   fifo_st [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fifo_count;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              capture;
  logic              pop;

  // Every live pipeline stage holds a credit until its result leaves the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= LATENCY; i++) begin
      inflight = inflight + OCC_W'(vld_pipe[i]);
    end
  end

  always_comb begin
    occupancy = OCC_W'(fifo_count) + inflight;
    in_ready  = rst && (occupancy < OCC_W'(DEPTH));
    issue     = in_valid && in_ready;
    capture   = vld_pipe[LATENCY];
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    out_z      = fifo_z[rd_ptr];
    out_status = fifo_st[rd_ptr];
  end

  // Operand registers feeding the multiplier; hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (issue) begin
      mult_a <= in_a;
      mult_b <= in_b;
    end
  end

  // Shadow of the multiplier pipeline: which mult_z samples belong to a live issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_z[i]  <= '0;
        fifo_st[i] <= '0;
      end
    end else if (capture) begin
      fifo_z[wr_ptr]  <= mult_z;
      fifo_st[wr_ptr] <= mult_status;
    end
  end

  // Ring pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + FILL_W'(1);
        2'b01:   fifo_count <= fifo_count - FILL_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Clear takes effect before the popped status is folded in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_status <= '0;
      result_cnt    <= '0;
    end else begin
      if (pop) begin
        sticky_status <= (sticky_clr ? ST_W'(0) : sticky_status) | out_status;
        result_cnt    <= result_cnt + CNT_W'(1);
      end else if (sticky_clr) begin
        sticky_status <= '0;
      end
    end
  end

  // A capture into a full FIFO would mean the credit accounting is broken.
  always_ff @(posedge clk) begin
    if (rst && capture) begin
      assert (fifo_count < FILL_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fp_mult_stream_ctrl.sv
// Randomised scoreboard bench for fp_mult_stream_ctrl with a behavioural 2-stage FP multiplier.
module tb_fp_mult_stream_ctrl;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] mult_z;
  logic [7:0]  mult_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic        sticky_clr;
  logic [7:0]  sticky_status;
  logic [15:0] result_cnt;

  fp_mult_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_z(mult_z), .mult_status(mult_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_status(out_status),
    .sticky_clr(sticky_clr), .sticky_status(sticky_status), .result_cnt(result_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [7:0]  st;
    int          acc;
    int          arrive;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  logic        rst_q;
  bit          running = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mdl_cnt;
  logic [7:0]  mdl_sticky;
  logic [39:0] mul_s1;

  // Truncating single-precision multiply; status: 01 invalid, 02 inf, 04 zero, 08 inexact, 10 overflow, 20 underflow.
  function automatic logic [39:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    logic inexact;
    bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return {32'h7FC00000, 8'h01};
    if (inf_a || inf_b) return {s, 8'hFF, 23'h0, 8'h02};
    if (zero_a || zero_b) return {s, 31'h0, 8'h04};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      inexact = |p[23:0];
      e = e + 1;
    end else begin
      m = p[45:23];
      inexact = |p[22:0];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 8'h12};
    if (e <= 0) return {s, 31'h0, 8'h24};
    return {s, 8'(e), m, (inexact ? 8'h08 : 8'h00)};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    case ($urandom_range(0, 11))
      0: r = 32'h00000000;
      1: r = 32'h7F800000;
      2: r = 32'h7FC00001;
      3: r = 32'h00000001;
      4: r = 32'h78000000;
      default: r = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
    return r;
  endfunction

  // Behavioural multiplier: two registered stages after mult_a/mult_b.
  always @(posedge clk) begin
    mul_s1      <= fp_mul(mult_a, mult_b);
    mult_z      <= mul_s1[39:8];
    mult_status <= mul_s1[7:0];
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the scoreboard and retires popped results.
  always @(negedge clk) begin
    int   outstanding;
    logic exp_valid;
    exp_t head;
    if (running) begin
      if (!rst_q) begin
        mdl_cnt    = '0;
        mdl_sticky = '0;
      end
      outstanding = 0;
      foreach (sb[i]) if (sb[i].acc <= cyc) outstanding++;
      chk("in_ready", 40'(in_ready), 40'(rst && (outstanding < DEPTH)));
      exp_valid = (sb.size() > 0) && (sb[0].arrive <= cyc);
      chk("out_valid", 40'(out_valid), 40'(exp_valid));
      if (!rst_q) begin
        chk("rst_mult_ab", 40'({mult_a[19:0], mult_b[19:0]}), 40'(0));
        chk("rst_out_data", {out_z, out_status}, 40'(0));
      end
      if (out_valid && exp_valid) chk("out_data", {out_z, out_status}, {sb[0].z, sb[0].st});
      chk("result_cnt", 40'(result_cnt), 40'(mdl_cnt));
      chk("sticky_status", 40'(sticky_status), 40'(mdl_sticky));
      if (rst) begin
        if (out_valid && out_ready && sb.size() > 0) begin
          head = sb.pop_front();
          mdl_cnt = mdl_cnt + 16'd1;
          mdl_sticky = (sticky_clr ? 8'h00 : mdl_sticky) | head.st;
        end else if (sticky_clr) begin
          mdl_sticky = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_q) sb.delete();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic [39:0] r;
    r = fp_mul(a, b);
    sb.push_back('{z: r[39:8], st: r[7:0], acc: cyc + 1, arrive: cyc + LATENCY + 2});
  endtask

  // Offer one pair for one cycle; in_ready is state-only so it is final at this point.
  task automatic offer(input logic [31:0] a, input logic [31:0] b, output bit acc);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    acc = in_ready;
    if (acc) push(a, b);
    step();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit acc;
    int tries;
    tries = 0;
    do begin
      offer(a, b, acc);
      tries++;
      if (!acc && tries > 50) begin
        $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", tries);
        $fatal(1);
      end
    end while (!acc);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    in_valid = 1'b1;
    in_a = 32'h3F800000;
    in_b = 32'h40000000;
    out_ready = 1'b0;
    sticky_clr = 1'b0;

    // Reset held three cycles with in_valid asserted.
    step();
    running = 1;
    step();
    step();
    rst = 1'b1;
    idle(2);

    // Single operation, minimum latency.
    out_ready = 1'b1;
    send(32'h40000000, 32'h40400000);
    idle(6);

    // Back-to-back stream with the consumer always ready.
    send(32'h3FC00000, 32'h3FC00000);
    for (int i = 0; i < 7; i++) send(rnd_op(), rnd_op());
    idle(8);

    // Backpressure: consumer stalled, producer always valid.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) offer(rnd_op(), rnd_op(), acc);
    idle(3);
    out_ready = 1'b1;
    idle(8);

    // Sticky accumulation, then clear coinciding with the second pop.
    out_ready = 1'b0;
    send(32'h7F800000, 32'h00000000);
    send(32'h3FC00001, 32'h3FC00001);
    idle(5);
    out_ready = 1'b1;
    step();
    sticky_clr = 1'b1;
    step();
    out_ready = 1'b0;
    sticky_clr = 1'b0;
    idle(3);
    send(32'h7F800000, 32'h00000000);
    send(32'h40000000, 32'h40400000);
    idle(5);
    out_ready = 1'b1;
    idle(4);

    // Reset while three operations are in flight.
    send(32'h40000000, 32'h40400000);
    send(32'h3FC00000, 32'h3FC00000);
    send(32'h40800000, 32'h40400000);
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle(8);
    send(32'h40000000, 32'h40400000);
    idle(6);

    // Randomised traffic with random backpressure and sticky clears.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = rnd_op();
      b = rnd_op();
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = a;
      in_b = b;
      out_ready = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      if (in_valid && in_ready) push(a, b);
      step();
    end

    // Drain everything still outstanding.
    in_valid = 1'b0;
    sticky_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() > 0; i++) step();
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      $fatal(1);
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
